// File: rtl/seg_display_sched.sv
// ---------------------------------------------------------------------------
// seg_display_sched
//
// Purpose:
//    Arbitrates between two 14-bit value requesters and converts the granted
//    value to four BCD digits with a shift-add-3 (double-dabble) converter.
//    The converter handles one bit per clock. The digits are then
//    time-multiplexed onto the anode and digit bus that feeds the
//    BCD-to-segment decoder. The value is saturated to 9999, and leading
//    zeros can optionally be blanked.
//
// Parameters:
//    SCAN_DIV  width of the free-running scan prescaler; the scan advances one
//              digit every 2^SCAN_DIV clocks
//    BLANK_LZ  1 = replace leading-zero digits with 4'hF; ones never blanked
//
// Ports:
//    clk          system clock, rising edge
//    rst          asynchronous active-high reset
//    req0 / num0  requester 0 request and value (stable until ack0)
//    req1 / num1  requester 1 request and value (stable until ack1)
//    ack0 / ack1  one-cycle capture pulses
//    busy         high while a conversion is in flight (CONV, LOAD)
//    done         one-cycle pulse when new digits reach the display register
//    src          index of the requester whose value is displayed
//    an           active-low one-hot anode enables
//    digit        BCD code for the selected anode, 4'hF = blank
// ---------------------------------------------------------------------------
module seg_display_sched #(
   parameter int unsigned SCAN_DIV = 17,
   parameter logic        BLANK_LZ = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic [13:0] num0,
   input  logic        req1,
   input  logic [13:0] num1,
   output logic        ack0,
   output logic        ack1,
   output logic        busy,
   output logic        done,
   output logic        src,
   output logic [3:0]  an,
   output logic [3:0]  digit
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      LOAD = 2'd2
   } state_t;

   // Display register contents after reset: a plain 0, blanked if enabled.
   localparam logic [15:0] DISP_RST = BLANK_LZ ? 16'hFFF0 : 16'h0000;

   state_t              state_r;
   state_t              state_nxt_s;
   logic                grant_s;
   logic                gidx_s;
   logic [13:0]         num_sel_s;
   logic                prio_r;     // requester favoured when both request
   logic                gsrc_r;     // requester of the conversion in flight
   logic [13:0]         cap_r;
   logic [15:0]         acc_r;
   logic [3:0]          cnt_r;
   logic [15:0]         disp_r;
   logic [SCAN_DIV-1:0] pre_r;
   logic [1:0]          idx_r;

   // Clamp a 14-bit binary value to the 4-digit decimal range.
   function automatic logic [13:0] sat9999(input logic [13:0] v);
      logic [13:0] r;
      if (v > 14'd9999) begin
         r = 14'd9999;
      end else begin
         r = v;
      end
      return r;
   endfunction

   // One double-dabble step: correct each nibble >= 5, then shift in bit_in.
   function automatic logic [15:0] dabble_step(input logic [15:0] acc, input logic bit_in);
      logic [15:0] a;
      a = acc;
      for (int i = 0; i < 4; i++) begin
         if (a[4*i +: 4] >= 4'd5) begin
            a[4*i +: 4] = a[4*i +: 4] + 4'd3;
         end else begin
            a[4*i +: 4] = a[4*i +: 4];
         end
      end
      return {a[14:0], bit_in};
   endfunction

   // Leading-zero blanking from the thousands digit down; ones always shown.
   function automatic logic [15:0] blank_lz(input logic [15:0] d);
      logic [15:0] r;
      r = d;
      if (BLANK_LZ && (d[15:12] == 4'd0)) begin
         r[15:12] = 4'hF;
         if (d[11:8] == 4'd0) begin
            r[11:8] = 4'hF;
            if (d[7:4] == 4'd0) begin
               r[7:4] = 4'hF;
            end else begin
               r[7:4] = d[7:4];
            end
         end else begin
            r[11:8] = d[11:8];
         end
      end else begin
         r = d;
      end
      return r;
   endfunction

   // Active-low anode pattern for a scan index.
   function automatic logic [3:0] anode_of(input logic [1:0] idx);
      logic [3:0] r;
      case (idx)
         2'd0:    r = 4'b1110;
         2'd1:    r = 4'b1101;
         2'd2:    r = 4'b1011;
         2'd3:    r = 4'b0111;
         default: r = 4'b1111;
      endcase
      return r;
   endfunction

   // Digit of the display register selected by a scan index.
   function automatic logic [3:0] digit_of(input logic [15:0] d, input logic [1:0] idx);
      logic [3:0] r;
      case (idx)
         2'd0:    r = d[3:0];
         2'd1:    r = d[7:4];
         2'd2:    r = d[11:8];
         2'd3:    r = d[15:12];
         default: r = 4'hF;
      endcase
      return r;
   endfunction

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic and round-robin arbitration (requests only seen in IDLE).
   always_comb begin
      state_nxt_s = state_r;
      grant_s     = 1'b0;
      gidx_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (req0 && req1) begin
               grant_s = 1'b1;
               gidx_s  = prio_r;
            end else if (req0) begin
               grant_s = 1'b1;
               gidx_s  = 1'b0;
            end else if (req1) begin
               grant_s = 1'b1;
               gidx_s  = 1'b1;
            end else begin
               grant_s = 1'b0;
               gidx_s  = 1'b0;
            end
            if (grant_s) begin
               state_nxt_s = CONV;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         CONV: begin
            if (cnt_r == 4'd0) begin
               state_nxt_s = LOAD;
            end else begin
               state_nxt_s = CONV;
            end
         end
         LOAD:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   assign num_sel_s = gidx_s ? num1 : num0;

   // Capture, conversion datapath, display register and handshake outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ack0   <= 1'b0;
         ack1   <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         src    <= 1'b0;
         prio_r <= 1'b0;
         gsrc_r <= 1'b0;
         cap_r  <= 14'd0;
         acc_r  <= 16'd0;
         cnt_r  <= 4'd0;
         disp_r <= DISP_RST;
      end else begin
         ack0 <= grant_s && !gidx_s;
         ack1 <= grant_s && gidx_s;
         busy <= (state_nxt_s != IDLE);
         done <= (state_r == LOAD);
         case (state_r)
            IDLE: begin
               if (grant_s) begin
                  cap_r  <= sat9999(num_sel_s);
                  acc_r  <= 16'd0;
                  cnt_r  <= 4'd13;
                  gsrc_r <= gidx_s;
                  prio_r <= ~gidx_s;
               end
            end
            CONV: begin
               acc_r <= dabble_step(acc_r, cap_r[cnt_r]);
               cnt_r <= cnt_r - 4'd1;
            end
            LOAD: begin
               disp_r <= blank_lz(acc_r);
               src    <= gsrc_r;
            end
            default: begin
               acc_r <= 16'd0;
               cnt_r <= 4'd0;
            end
         endcase
      end
   end

   // Free-running scan: on every prescaler wrap show digit idx, then advance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_r <= '0;
         idx_r <= 2'd0;
         an    <= 4'b1111;
         digit <= 4'hF;
      end else begin
         pre_r <= pre_r + SCAN_DIV'(1);
         if (pre_r == {SCAN_DIV{1'b1}}) begin
            an    <= anode_of(idx_r);
            digit <= digit_of(disp_r, idx_r);
            idx_r <= idx_r + 2'd1;
         end
      end
   end

endmodule

// File: tb/tb_seg_display_sched.sv
// ---------------------------------------------------------------------------
// tb_seg_display_sched
//
// Purpose:
//    Self-checking bench for seg_display_sched with SCAN_DIV=2. Two instances
//    share the same inputs: one with blanking enabled and one with it
//    disabled. Every request pushes its expected display contents to a
//    scoreboard, and the ack/done pulses pop and compare them. A display
//    model follows the scan and checks an/digit at every prescaler wrap.
// ---------------------------------------------------------------------------
module tb_seg_display_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0 = 1'b0;
   logic        req1 = 1'b0;
   logic [13:0] num0 = 14'd0;
   logic [13:0] num1 = 14'd0;
   logic        ack0, ack1, busy, done, src;
   logic [3:0]  an, digit;
   logic        ack0_nb, ack1_nb, busy_nb, done_nb, src_nb;
   logic [3:0]  an_nb, digit_nb;

   typedef struct {
      bit          sel;
      logic [15:0] d;
      logic [15:0] nb;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   edge_n   = 0;
   int   ack_edge = 0;
   int   prev_ack = 0;
   bit   prev_valid = 1'b0;
   bit   chk_spacing = 1'b0;
   logic [15:0] model_d  = 16'hFFF0;
   logic [15:0] model_nb = 16'h0000;

   seg_display_sched #(.SCAN_DIV(2), .BLANK_LZ(1'b1)) u_dut (
      .clk(clk), .rst(rst), .req0(req0), .num0(num0), .req1(req1), .num1(num1),
      .ack0(ack0), .ack1(ack1), .busy(busy), .done(done), .src(src),
      .an(an), .digit(digit)
   );

   seg_display_sched #(.SCAN_DIV(2), .BLANK_LZ(1'b0)) u_nb (
      .clk(clk), .rst(rst), .req0(req0), .num0(num0), .req1(req1), .num1(num1),
      .ack0(ack0_nb), .ack1(ack1_nb), .busy(busy_nb), .done(done_nb), .src(src_nb),
      .an(an_nb), .digit(digit_nb)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference decimal digits of a value after saturation and optional blanking.
   function automatic logic [15:0] exp_disp(input int v, input bit blank);
      int          s;
      logic [3:0]  d3, d2, d1, d0;
      logic [15:0] r;
      s  = (v > 9999) ? 9999 : v;
      d0 = 4'(s % 10);
      d1 = 4'((s / 10) % 10);
      d2 = 4'((s / 100) % 10);
      d3 = 4'(s / 1000);
      r  = {d3, d2, d1, d0};
      if (blank && d3 == 4'd0) begin
         r[15:12] = 4'hF;
         if (d2 == 4'd0) begin
            r[11:8] = 4'hF;
            if (d1 == 4'd0) r[7:4] = 4'hF;
         end
      end
      return r;
   endfunction

   // Monitor: scan model, ack/done scoreboard checks, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst) begin
         edge_n   = 0;
         model_d  = 16'hFFF0;
         model_nb = 16'h0000;
         sb.delete();
         prev_valid = 1'b0;
      end else begin
         edge_n++;
         if (edge_n % 4 == 0) begin
            int         idx;
            logic [3:0] a_exp;
            idx   = ((edge_n / 4) - 1) % 4;
            a_exp = ~(4'b0001 << idx);
            check_eq("scan_an", an, a_exp);
            check_eq("scan_digit", digit, model_d[4*idx +: 4]);
            check_eq("scan_an_nb", an_nb, a_exp);
            check_eq("scan_digit_nb", digit_nb, model_nb[4*idx +: 4]);
         end
         if (!chk_spacing) prev_valid = 1'b0;
         if (ack0 || ack1) begin
            check_eq("ack_expected", (sb.size() > 0), 1);
            check_eq("ack_onehot", {ack1, ack0} != 2'b11, 1);
            if (sb.size() > 0) begin
               check_eq("ack_sel", {ack1, ack0}, sb[0].sel ? 2'b10 : 2'b01);
               check_eq("ack_sel_nb", {ack1_nb, ack0_nb}, sb[0].sel ? 2'b10 : 2'b01);
            end
            check_eq("busy_at_ack", {busy, busy_nb}, 2'b11);
            if (chk_spacing && prev_valid) check_eq("ack_spacing", edge_n - prev_ack, 16);
            prev_ack   = edge_n;
            prev_valid = 1'b1;
            ack_edge   = edge_n;
         end
         if (done) begin
            check_eq("done_expected", (sb.size() > 0), 1);
            if (sb.size() > 0) begin
               exp_t e;
               e = sb.pop_front();
               check_eq("done_src", src, e.sel);
               check_eq("done_src_nb", src_nb, e.sel);
               check_eq("done_latency", edge_n - ack_edge, 15);
               check_eq("busy_at_done", busy, 0);
               check_eq("done_nb", done_nb, 1);
               model_d  = e.d;
               model_nb = e.nb;
            end
         end
      end
   end

   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;
   endtask

   // One request, optionally changing num0 while the conversion is in flight.
   task automatic send(input bit sel, input int val, input bit chg);
      int   t;
      exp_t e;
      e.sel = sel;
      e.d   = exp_disp(val, 1'b1);
      e.nb  = exp_disp(val, 1'b0);
      sb.push_back(e);
      @(negedge clk);
      if (sel) begin
         num1 = 14'(val);
         req1 = 1'b1;
      end else begin
         num0 = 14'(val);
         req0 = 1'b1;
      end
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!(sel ? ack1 : ack0) && t < 40);
      check_eq("ack_timeout", (t < 40), 1);
      req0 = 1'b0;
      req1 = 1'b0;
      if (chg) num0 = 14'd5555;
      repeat (36) @(negedge clk);
   endtask

   initial begin
      int   t;
      int   acks;
      exp_t e;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_an", an, 4'b1111);
      check_eq("rst_digit", digit, 4'hF);
      check_eq("rst_flags", {ack0, ack1, busy, done, src}, 5'b0);
      @(negedge clk);
      #1 rst = 1'b0;
      repeat (20) @(negedge clk);

      send(1'b0, 1234, 1'b0);
      send(1'b1, 12000, 1'b0);
      send(1'b0, 16383, 1'b0);
      send(1'b0, 7, 1'b0);
      send(1'b0, 0, 1'b0);
      send(1'b0, 42, 1'b1);

      // Both requesters held high after a fresh reset: 0,1,0,1 every 16 clocks.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         e.sel = (i % 2 == 1);
         e.d   = exp_disp(e.sel ? 22 : 11, 1'b1);
         e.nb  = exp_disp(e.sel ? 22 : 11, 1'b0);
         sb.push_back(e);
      end
      chk_spacing = 1'b1;
      @(negedge clk);
      num0 = 14'd11;
      num1 = 14'd22;
      req0 = 1'b1;
      req1 = 1'b1;
      acks = 0;
      t    = 0;
      while (acks < 4 && t < 200) begin
         @(negedge clk);
         t++;
         if (ack0 || ack1) acks++;
      end
      check_eq("alt_timeout", (t < 200), 1);
      req0 = 1'b0;
      req1 = 1'b0;
      repeat (36) @(negedge clk);
      chk_spacing = 1'b0;
      check_eq("alt_drained", sb.size(), 0);

      // Reset in the middle of a conversion.
      e.sel = 1'b0;
      e.d   = exp_disp(1234, 1'b1);
      e.nb  = exp_disp(1234, 1'b0);
      sb.push_back(e);
      @(negedge clk);
      num0 = 14'd1234;
      req0 = 1'b1;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!ack0 && t < 40);
      check_eq("midrst_ack_timeout", (t < 40), 1);
      req0 = 1'b0;
      repeat (7) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check_eq("midrst_an", an, 4'b1111);
      check_eq("midrst_digit", digit, 4'hF);
      check_eq("midrst_flags", {ack0, ack1, busy, done, src}, 5'b0);
      repeat (3) @(negedge clk);
      #1 rst = 1'b0;
      repeat (30) @(negedge clk);
      send(1'b0, 1234, 1'b0);
      check_eq("final_drained", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
